// File: rtl/fractal_sync_req_tx.sv
// Core-side requester for fractal barrier sync: accepts (level,id) requests, issues them to the tree,
// tracks them in an outstanding table and matches wake-up responses. Optional FRACTAL_SYNC_TIMEOUT_EN adds per-entry timeouts.
module fractal_sync_req_tx #(
  parameter int unsigned LEVEL_WIDTH    = 1,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned N_OUTSTANDING  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sync_valid_i,
  output logic                   sync_ready_o,
  input  logic [LEVEL_WIDTH-1:0] sync_level_i,
  input  logic [ID_WIDTH-1:0]    sync_id_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [LEVEL_WIDTH-1:0] req_level_o,
  output logic [ID_WIDTH-1:0]    req_id_o,
  input  logic                   rsp_valid_i,
  input  logic [LEVEL_WIDTH-1:0] rsp_level_i,
  input  logic [ID_WIDTH-1:0]    rsp_id_i,
  input  logic                   rsp_err_i,
  output logic                   done_o,
  output logic [LEVEL_WIDTH-1:0] done_level_o,
  output logic [ID_WIDTH-1:0]    done_id_o,
  output logic                   done_err_o,
  output logic                   dup_err_o,
  output logic                   stray_err_o,
  output logic                   timeout_o
);

  localparam int unsigned IDX_W = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;

  if (N_OUTSTANDING < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fractal_sync_req_tx: N_OUTSTANDING and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {ST_FREE, ST_ISSUE, ST_WAIT} entry_st_e;

  entry_st_e              state_q [N_OUTSTANDING];
  logic [LEVEL_WIDTH-1:0] lvl_q   [N_OUTSTANDING];
  logic [ID_WIDTH-1:0]    id_q    [N_OUTSTANDING];
  logic [IDX_W-1:0]       issue_idx_q;

  logic                   req_valid_q;
  logic [LEVEL_WIDTH-1:0] req_level_q;
  logic [ID_WIDTH-1:0]    req_id_q;
  logic                   done_q, done_err_q, dup_q, stray_q, timeout_q;
  logic [LEVEL_WIDTH-1:0] done_level_q;
  logic [ID_WIDTH-1:0]    done_id_q;

  logic                     any_free, dup_hit, core_hs, tree_hs, rsp_hit;
  logic [IDX_W-1:0]         alloc_idx;
  logic [N_OUTSTANDING-1:0] match_vec, expired_vec;

`ifdef FRACTAL_SYNC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q [N_OUTSTANDING];
`endif

  assign tree_hs      = req_valid_q & req_ready_i;
  assign sync_ready_o = any_free & (~req_valid_q | req_ready_i);
  assign core_hs      = sync_valid_i & sync_ready_o;
  assign rsp_hit      = |match_vec;

  // Entry handshaking to the tree this cycle is already eligible for a response match.
  always_comb begin
    any_free    = 1'b0;
    alloc_idx   = '0;
    dup_hit     = 1'b0;
    match_vec   = '0;
    expired_vec = '0;
    for (int i = 0; i < N_OUTSTANDING; i++) begin
      if (state_q[i] == ST_FREE && !any_free) begin
        any_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (state_q[i] != ST_FREE && lvl_q[i] == sync_level_i && id_q[i] == sync_id_i)
        dup_hit = 1'b1;
      if (rsp_valid_i && lvl_q[i] == rsp_level_i && id_q[i] == rsp_id_i &&
          (state_q[i] == ST_WAIT || (state_q[i] == ST_ISSUE && tree_hs)))
        match_vec[i] = 1'b1;
`ifdef FRACTAL_SYNC_TIMEOUT_EN
      if (state_q[i] == ST_WAIT && cnt_q[i] == CNT_W'(TIMEOUT_CYCLES) && !match_vec[i])
        expired_vec[i] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_OUTSTANDING; i++) begin
        state_q[i] <= ST_FREE;
        lvl_q[i]   <= '0;
        id_q[i]    <= '0;
`ifdef FRACTAL_SYNC_TIMEOUT_EN
        cnt_q[i]   <= '0;
`endif
      end
      issue_idx_q  <= '0;
      req_valid_q  <= 1'b0;
      req_level_q  <= '0;
      req_id_q     <= '0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
      done_level_q <= '0;
      done_id_q    <= '0;
      dup_q        <= 1'b0;
      stray_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q     <= rsp_hit;
      done_err_q <= rsp_hit & rsp_err_i;
      stray_q    <= rsp_valid_i & ~rsp_hit;
      dup_q      <= core_hs & dup_hit;
      timeout_q  <= |expired_vec;
      if (rsp_hit) begin
        done_level_q <= rsp_level_i;
        done_id_q    <= rsp_id_i;
      end
      // Later assignments win: issue->WAIT, then match/expiry->FREE, then new allocation.
      for (int i = 0; i < N_OUTSTANDING; i++) begin
`ifdef FRACTAL_SYNC_TIMEOUT_EN
        if (state_q[i] == ST_WAIT) cnt_q[i] <= cnt_q[i] + 1'b1;
`endif
        if (tree_hs && issue_idx_q == IDX_W'(i)) begin
          state_q[i] <= ST_WAIT;
`ifdef FRACTAL_SYNC_TIMEOUT_EN
          cnt_q[i]   <= '0;
`endif
        end
        if (match_vec[i] || expired_vec[i]) state_q[i] <= ST_FREE;
        if (core_hs && !dup_hit && alloc_idx == IDX_W'(i)) begin
          state_q[i] <= ST_ISSUE;
          lvl_q[i]   <= sync_level_i;
          id_q[i]    <= sync_id_i;
        end
      end
      if (core_hs && !dup_hit) begin
        issue_idx_q <= alloc_idx;
        req_valid_q <= 1'b1;
        req_level_q <= sync_level_i;
        req_id_q    <= sync_id_i;
      end else if (tree_hs) begin
        req_valid_q <= 1'b0;
      end
    end
  end

  assign req_valid_o  = req_valid_q;
  assign req_level_o  = req_level_q;
  assign req_id_o     = req_id_q;
  assign done_o       = done_q;
  assign done_err_o   = done_err_q;
  assign done_level_o = done_level_q;
  assign done_id_o    = done_id_q;
  assign dup_err_o    = dup_q;
  assign stray_err_o  = stray_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_fractal_sync_req_tx.sv
// Bench for fractal_sync_req_tx: directed steps then random traffic, every cycle checked against
// a set-based model of outstanding barriers (timeouts modelled when FRACTAL_SYNC_TIMEOUT_EN is defined).
module tb_fractal_sync_req_tx;
  localparam int LW = 2, IW = 2, NO = 2, TO = 8;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic sync_valid_i = 0, req_ready_i = 0, rsp_valid_i = 0, rsp_err_i = 0;
  logic [LW-1:0] sync_level_i = 0, rsp_level_i = 0;
  logic [IW-1:0] sync_id_i = 0, rsp_id_i = 0;
  logic sync_ready_o, req_valid_o, done_o, done_err_o, dup_err_o, stray_err_o, timeout_o;
  logic [LW-1:0] req_level_o, done_level_o;
  logic [IW-1:0] req_id_o, done_id_o;

  fractal_sync_req_tx #(.LEVEL_WIDTH(LW), .ID_WIDTH(IW), .N_OUTSTANDING(NO), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sync_valid_i(sync_valid_i), .sync_ready_o(sync_ready_o),
    .sync_level_i(sync_level_i), .sync_id_i(sync_id_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_level_o(req_level_o), .req_id_o(req_id_o),
    .rsp_valid_i(rsp_valid_i), .rsp_level_i(rsp_level_i), .rsp_id_i(rsp_id_i), .rsp_err_i(rsp_err_i),
    .done_o(done_o), .done_level_o(done_level_o), .done_id_o(done_id_o), .done_err_o(done_err_o),
    .dup_err_o(dup_err_o), .stray_err_o(stray_err_o), .timeout_o(timeout_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  // Model: outstanding barriers keyed by (level,id); value 0 = awaiting tree accept, 1 = waiting for wake-up.
  int st[int];
  int age[int];
  logic m_req_valid = 0;
  int   m_req_key = 0;
  logic e_done = 0, e_derr = 0, e_dup = 0, e_stray = 0, e_to = 0;
  int   e_dkey = 0;

  function automatic int key(input logic [LW-1:0] l, input logic [IW-1:0] i);
    return int'(l) * 4 + int'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit ready, core_hs, tree_hs, matched, dup, to;
    int sk, rk;
    int exp_q[$];
    #1;
    ready   = (st.num() < NO) && (!m_req_valid || req_ready_i);
    if (!rst_i) chk("sync_ready", sync_ready_o, ready);
    sk      = key(sync_level_i, sync_id_i);
    rk      = key(rsp_level_i, rsp_id_i);
    core_hs = sync_valid_i && ready;
    tree_hs = m_req_valid && req_ready_i;
    matched = rsp_valid_i && st.exists(rk) && (st[rk] == 1 || (tree_hs && m_req_key == rk));
    dup     = core_hs && st.exists(sk);
    to      = 0;
`ifdef FRACTAL_SYNC_TIMEOUT_EN
    foreach (st[k]) if (st[k] == 1 && !(matched && k == rk)) begin
      if (age[k] == TO) exp_q.push_back(k);
      else age[k] = age[k] + 1;
    end
`endif
    if (tree_hs) begin st[m_req_key] = 1; age[m_req_key] = 0; end
    if (matched) st.delete(rk);
    foreach (exp_q[j]) begin st.delete(exp_q[j]); to = 1; end
    e_done  = matched;
    e_derr  = matched && rsp_err_i;
    if (matched) e_dkey = rk;
    e_dup   = dup;
    e_stray = rsp_valid_i && !matched;
    e_to    = to;
    if (core_hs && !dup) begin st[sk] = 0; m_req_valid = 1; m_req_key = sk; end
    else if (tree_hs) m_req_valid = 0;
    if (rst_i) begin
      st.delete(); age.delete();
      m_req_valid = 0; m_req_key = 0;
      e_done = 0; e_derr = 0; e_dup = 0; e_stray = 0; e_to = 0; e_dkey = 0;
    end
    @(posedge clk_i); #1;
    chk("req_valid", req_valid_o, m_req_valid);
    chk("req_key", key(req_level_o, req_id_o), m_req_key);
    chk("done", done_o, e_done);
    chk("done_key", key(done_level_o, done_id_o), e_dkey);
    chk("done_err", done_err_o, e_derr);
    chk("dup_err", dup_err_o, e_dup);
    chk("stray_err", stray_err_o, e_stray);
    chk("timeout", timeout_o, e_to);
  endtask

  task automatic drive(input bit sv, input int sl, input int si, input bit rr,
                       input bit rv, input int rl, input int ri, input bit re);
    sync_valid_i = sv; sync_level_i = LW'(sl); sync_id_i = IW'(si); req_ready_i = rr;
    rsp_valid_i = rv; rsp_level_i = LW'(rl); rsp_id_i = IW'(ri); rsp_err_i = re;
    step();
  endtask

  initial begin
    bit seen;
    int r;
    #1;
    rst_i = 1; drive(0,0,0,0, 0,0,0,0); drive(0,0,0,0, 0,0,0,0);
    rst_i = 0;
    #1 chk("reset_ready", sync_ready_o, 1);
    chk("reset_req_valid", req_valid_o, 0);
    // basic request / response
    drive(1,1,3,1, 0,0,0,0);
    chk("first_req_valid", req_valid_o, 1);
    chk("first_req_id", req_id_o, 3);
    drive(0,0,0,1, 0,0,0,0);
    drive(0,0,0,1, 1,1,3,0);
    chk("first_done", done_o, 1);
    chk("first_done_id", done_id_o, 3);
    // fill the table
    drive(1,0,0,1, 0,0,0,0); drive(1,0,1,1, 0,0,0,0); drive(0,0,0,1, 0,0,0,0);
    #1 chk("full_not_ready", sync_ready_o, 0);
    drive(0,0,0,1, 1,0,0,0);
    chk("full_ready_after_done", sync_ready_o, 1);
    drive(0,0,0,1, 1,0,1,0);
    // tree backpressure
    drive(1,2,1,0, 0,0,0,0);
    for (int i = 0; i < 5; i++) drive(0,0,0,0, 0,0,0,0);
    chk("bp_req_id", req_id_o, 1);
    drive(0,0,0,1, 0,0,0,0);
    drive(0,0,0,1, 1,2,1,0);
    // duplicate, error response, stray
    drive(1,1,1,1, 0,0,0,0); drive(1,1,1,1, 0,0,0,0);
    chk("dup_pulse", dup_err_o, 1);
    drive(0,0,0,1, 1,1,1,1);
    chk("err_done", done_err_o, 1);
    drive(0,0,0,1, 1,0,2,0);
    chk("stray_pulse", stray_err_o, 1);
    // response while still in ISSUE is stray; response during tree handshake matches
    drive(1,3,0,0, 0,0,0,0); drive(0,0,0,0, 1,3,0,0); drive(0,0,0,1, 1,3,0,0);
    chk("hs_cycle_match", done_o, 1);
`ifdef FRACTAL_SYNC_TIMEOUT_EN
    drive(1,3,3,1, 0,0,0,0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(0,0,0,1, 0,0,0,0);
      seen = timeout_o;
    end
    chk("timeout_seen", seen, 1);
    drive(0,0,0,1, 1,3,3,0);
    chk("late_rsp_stray", stray_err_o, 1);
`endif
    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 1) ? m_req_key : int'($urandom_range(0, 15));
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, r / 4, r % 4, $urandom_range(0, 1));
    end
    rst_i = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
